// File: rtl/pe_wbuf.sv
// Weight-stationary MAC processing element with a local weight FIFO; MAC and weight-chain outputs register in 1 cycle.
// No backpressure: a push into a full FIFO is dropped and latches ovf_err; a swap on an empty FIFO is ignored.
module pe_wbuf #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_in,
    input  logic                  signed_in,
    input  logic                  sat_in,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic [ACC_WIDTH-1:0]  psum_in,
    input  logic                  w_wen_in,
    input  logic [DATA_WIDTH-1:0] w_in,
    input  logic                  w_push_in,
    input  logic                  w_swap_in,
    input  logic                  w_clear_in,
    output logic                  en_out,
    output logic                  signed_out,
    output logic                  sat_out,
    output logic [DATA_WIDTH-1:0] pass_out,
    output logic [ACC_WIDTH-1:0]  psum_out,
    output logic                  w_wen_out,
    output logic [DATA_WIDTH-1:0] w_out,
    output logic                  wbuf_full,
    output logic                  wbuf_empty,
    output logic                  w_valid,
    output logic                  ovf_err,
    output logic                  sat_flag
);

    localparam int AW  = $clog2(WBUF_DEPTH);
    localparam int PW  = 2 * DATA_WIDTH;
    localparam int EXT = ACC_WIDTH + 1 - PW;

    logic [DATA_WIDTH-1:0] mem [WBUF_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic [DATA_WIDTH-1:0] w_act;
    logic                  push_req, push, pop;

    assign wbuf_full  = (count == (AW+1)'(WBUF_DEPTH));
    assign wbuf_empty = (count == '0);
    assign push_req   = w_push_in & w_wen_in;
    assign pop        = w_swap_in & ~wbuf_empty;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign push       = push_req & (~wbuf_full | pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= w_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
            w_act   <= '0;
            w_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push_req & wbuf_full & ~pop) begin
                ovf_err <= 1'b1;
            end
            if (pop) begin
                w_act   <= mem[rd_ptr];
                w_valid <= 1'b1;
            end else if (w_clear_in) begin
                w_act   <= '0;
                w_valid <= 1'b0;
            end
        end
    end

    logic [PW-1:0]        a_ext, b_ext, prod;
    logic [ACC_WIDTH:0]   prod_x, psum_x, sum;
    logic [ACC_WIDTH-1:0] sum_res;
    logic                 clamp;

    // Operands are extended to the product width so a plain multiply truncated to PW bits is exact for both signednesses.
    assign a_ext  = signed_in ? {{DATA_WIDTH{in[DATA_WIDTH-1]}}, in}       : {{DATA_WIDTH{1'b0}}, in};
    assign b_ext  = signed_in ? {{DATA_WIDTH{w_act[DATA_WIDTH-1]}}, w_act} : {{DATA_WIDTH{1'b0}}, w_act};
    assign prod   = w_valid ? (a_ext * b_ext) : '0;
    assign prod_x = {{EXT{signed_in & prod[PW-1]}}, prod};
    assign psum_x = {signed_in & psum_in[ACC_WIDTH-1], psum_in};
    assign sum    = psum_x + prod_x;

    always_comb begin
        clamp   = 1'b0;
        sum_res = sum[ACC_WIDTH-1:0];
        if (sat_in) begin
            if (signed_in) begin
                if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
                    clamp   = 1'b1;
                    sum_res = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
                end
            end else if (sum[ACC_WIDTH]) begin
                clamp   = 1'b1;
                sum_res = '1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_out     <= 1'b0;
            signed_out <= 1'b0;
            sat_out    <= 1'b0;
            pass_out   <= '0;
            psum_out   <= '0;
            sat_flag   <= 1'b0;
            w_wen_out  <= 1'b0;
            w_out      <= '0;
        end else begin
            w_wen_out <= w_wen_in;
            w_out     <= w_wen_in ? w_in : '0;
            en_out    <= en_in;
            if (en_in) begin
                pass_out   <= in;
                signed_out <= signed_in;
                sat_out    <= sat_in;
                psum_out   <= sum_res;
                sat_flag   <= clamp;
            end else begin
                sat_flag   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pe_wbuf.sv
// Randomized and directed bench for pe_wbuf against a queue-based behavioural model.
module tb_pe_wbuf;

    localparam int DEPTH = 4;

    logic        clk, rst;
    logic        en_in, signed_in, sat_in, w_wen_in, w_push_in, w_swap_in, w_clear_in;
    logic [15:0] act_in, w_in;
    logic [31:0] psum_in;
    logic        en_out, signed_out, sat_out, w_wen_out, wbuf_full, wbuf_empty, w_valid, ovf_err, sat_flag;
    logic [15:0] pass_out, w_out;
    logic [31:0] psum_out;

    pe_wbuf #(.DATA_WIDTH(16), .ACC_WIDTH(32), .WBUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en_in(en_in), .signed_in(signed_in), .sat_in(sat_in),
        .in(act_in), .psum_in(psum_in), .w_wen_in(w_wen_in), .w_in(w_in),
        .w_push_in(w_push_in), .w_swap_in(w_swap_in), .w_clear_in(w_clear_in),
        .en_out(en_out), .signed_out(signed_out), .sat_out(sat_out), .pass_out(pass_out),
        .psum_out(psum_out), .w_wen_out(w_wen_out), .w_out(w_out), .wbuf_full(wbuf_full),
        .wbuf_empty(wbuf_empty), .w_valid(w_valid), .ovf_err(ovf_err), .sat_flag(sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [15:0] wq[$];
    logic [15:0] m_wact, m_pass, m_wout;
    logic [31:0] m_psum;
    bit          m_wval, m_ovf, m_en, m_sgn, m_sat, m_flag, m_wen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mac_ref(input logic [15:0] a, input logic [15:0] w, input logic [31:0] p,
                                            input bit sg, input bit sat, input bit wv, output bit flag);
        longint av, bv, pv, s, lo, hi;
        if (sg) begin
            av = longint'($signed(a));
            bv = longint'($signed(w));
            pv = longint'($signed(p));
            lo = -(longint'(1) << 31);
            hi = (longint'(1) << 31) - 1;
        end else begin
            av = longint'(a);
            bv = longint'(w);
            pv = longint'(p);
            lo = 0;
            hi = (longint'(1) << 32) - 1;
        end
        s    = pv + (wv ? av * bv : 0);
        flag = 1'b0;
        if (sat) begin
            if (s > hi) begin
                s = hi; flag = 1'b1;
            end else if (s < lo) begin
                s = lo; flag = 1'b1;
            end
        end
        return s[31:0];
    endfunction

    task automatic model_reset();
        wq.delete();
        m_wact = '0; m_pass = '0; m_wout = '0; m_psum = '0;
        m_wval = 0; m_ovf = 0; m_en = 0; m_sgn = 0; m_sat = 0; m_flag = 0; m_wen = 0;
    endtask

    task automatic model_update();
        bit f, pop, full;
        if (en_in) begin
            m_psum = mac_ref(act_in, m_wact, psum_in, signed_in, sat_in, m_wval, f);
            m_flag = f;
            m_pass = act_in; m_sgn = signed_in; m_sat = sat_in; m_en = 1;
        end else begin
            m_en = 0; m_flag = 0;
        end
        m_wen  = w_wen_in;
        m_wout = w_wen_in ? w_in : 16'h0;
        full = (wq.size() == DEPTH);
        pop  = w_swap_in && (wq.size() > 0);
        if (pop) begin
            m_wact = wq.pop_front();
            m_wval = 1;
        end else if (w_clear_in) begin
            m_wact = '0;
            m_wval = 0;
        end
        if (w_push_in && w_wen_in) begin
            if (full && !pop) m_ovf = 1;
            else wq.push_back(w_in);
        end
    endtask

    task automatic compare_all();
        check("psum_out", psum_out, m_psum);
        check("pass_out", pass_out, m_pass);
        check("en_out", en_out, m_en);
        check("signed_out", signed_out, m_sgn);
        check("sat_out", sat_out, m_sat);
        check("sat_flag", sat_flag, m_flag);
        check("w_valid", w_valid, m_wval);
        check("ovf_err", ovf_err, m_ovf);
        check("w_wen_out", w_wen_out, m_wen);
        check("w_out", w_out, m_wout);
        check("wbuf_full", wbuf_full, wq.size() == DEPTH);
        check("wbuf_empty", wbuf_empty, wq.size() == 0);
    endtask

    task automatic idle();
        en_in = 0; signed_in = 0; sat_in = 0; w_wen_in = 0; w_push_in = 0;
        w_swap_in = 0; w_clear_in = 0; act_in = '0; w_in = '0; psum_in = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_update();
        compare_all();
    endtask

    task automatic push_w(input logic [15:0] v);
        idle(); w_wen_in = 1; w_push_in = 1; w_in = v;
        tick();
    endtask

    task automatic mac(input logic [15:0] a, input logic [31:0] p, input bit sg, input bit sat);
        idle(); en_in = 1; act_in = a; psum_in = p; signed_in = sg; sat_in = sat;
        tick();
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 4))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 4))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        idle();
        rst = 1'b1;
        #12;
        rst = 1'b0;
        model_reset();
        compare_all();
        check("reset_empty", wbuf_empty, 1'b1);

        // signed MAC with w=-3
        push_w(16'hFFFD);
        idle(); w_swap_in = 1; tick();
        mac(16'd5, 32'd100, 1, 0);
        check("mac_signed_psum", psum_out, 32'd85);
        check("mac_en_out", en_out, 1'b1);
        check("mac_pass_out", pass_out, 16'd5);

        // saturation vs wrap
        push_w(16'h7FFF);
        idle(); w_swap_in = 1; tick();
        mac(16'h7FFF, 32'h7FFF_FFFF, 1, 1);
        check("sat_psum", psum_out, 32'h7FFF_FFFF);
        check("sat_flag_set", sat_flag, 1'b1);
        mac(16'h7FFF, 32'h7FFF_FFFF, 1, 0);
        check("wrap_psum", psum_out, 32'hBFFF_0000);
        check("wrap_flag", sat_flag, 1'b0);

        // clear and weight-chain forward
        idle(); w_clear_in = 1; tick();
        idle(); en_in = 1; act_in = 16'd123; psum_in = 32'd7; w_wen_in = 1; w_in = 16'd9; tick();
        check("clear_psum", psum_out, 32'd7);
        check("w_out_fwd", w_out, 16'd9);
        idle(); tick();
        check("w_out_drop", w_out, 16'd0);

        // FIFO fill, overflow, drain
        for (int k = 1; k <= 4; k++) push_w(16'(k));
        check("fill_full", wbuf_full, 1'b1);
        push_w(16'd5);
        check("ovf_set", ovf_err, 1'b1);
        check("ovf_still_full", wbuf_full, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            idle(); w_swap_in = 1; tick();
            mac(16'd1, 32'd0, 0, 0);
            check("drain_w_act", psum_out, 32'(k));
        end
        check("drain_empty", wbuf_empty, 1'b1);

        // simultaneous events
        for (int k = 10; k <= 13; k++) push_w(16'(k));
        idle(); w_wen_in = 1; w_push_in = 1; w_in = 16'd14; w_swap_in = 1; tick();
        check("full_push_swap", wbuf_full, 1'b1);
        for (int k = 0; k < 4; k++) begin
            idle(); w_swap_in = 1; tick();
        end
        idle(); w_clear_in = 1; tick();
        check("clear_w_valid", w_valid, 1'b0);
        idle(); w_wen_in = 1; w_push_in = 1; w_in = 16'd20; w_swap_in = 1; tick();
        check("empty_push_swap_wv", w_valid, 1'b0);
        check("empty_push_swap_ne", wbuf_empty, 1'b0);
        idle(); w_swap_in = 1; tick();
        check("one_entry_popped", wbuf_empty, 1'b1);
        push_w(16'd30);
        idle(); w_swap_in = 1; w_clear_in = 1; tick();
        check("swap_beats_clear", w_valid, 1'b1);

        // mid-operation reset with two entries queued
        push_w(16'd40);
        push_w(16'd41);
        idle(); en_in = 1; act_in = 16'd3; psum_in = 32'd1; w_wen_in = 1; w_push_in = 1; w_in = 16'd5; w_swap_in = 1;
        #2;
        rst = 1'b1;
        #1;
        check("rst_psum", psum_out, 32'd0);
        check("rst_en_out", en_out, 1'b0);
        check("rst_w_valid", w_valid, 1'b0);
        check("rst_ovf", ovf_err, 1'b0);
        check("rst_full", wbuf_full, 1'b0);
        check("rst_empty", wbuf_empty, 1'b1);
        check("rst_pass", pass_out, 16'd0);
        check("rst_w_wen_out", w_wen_out, 1'b0);
        idle();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare_all();
        idle(); w_swap_in = 1; tick();
        check("post_rst_swap", w_valid, 1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            idle();
            en_in      = ($urandom_range(0, 9) < 7);
            signed_in  = 1'($urandom);
            sat_in     = 1'($urandom);
            act_in     = rnd16();
            psum_in    = rnd32();
            w_wen_in   = ($urandom_range(0, 9) < 6);
            w_push_in  = 1'($urandom);
            w_in       = rnd16();
            w_swap_in  = ($urandom_range(0, 9) < 3);
            w_clear_in = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_wbuf.md
PE_WBUF -- requirements
Module: pe_wbuf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand and weight width.
REQ-002 SHALL have parameter ACC_WIDTH, default 32, partial-sum width; legal values are >= 2*DATA_WIDTH.
REQ-003 SHALL have parameter WBUF_DEPTH, default 4, weight FIFO entries; legal values are a power of 2 and >= 2.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have port en_in  in  1  MAC valid for in/psum_in/signed_in/sat_in.
REQ-007 SHALL have port signed_in  in  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 SHALL have port sat_in  in  1  1 = saturating accumulate, 0 = wrapping.
REQ-009 SHALL have port in  in  DATA_WIDTH  activation.
REQ-010 SHALL have port psum_in  in  ACC_WIDTH  upstream partial sum.
REQ-011 SHALL have port w_wen_in  in  1  w_in valid on the weight chain.
REQ-012 SHALL have port w_in  in  DATA_WIDTH  weight-chain data.
REQ-013 SHALL have port w_push_in  in  1  capture w_in into the local FIFO.
REQ-014 SHALL have port w_swap_in  in  1  pop the FIFO head into the active weight.
REQ-015 SHALL have port w_clear_in  in  1  invalidate the active weight.
REQ-016 SHALL have ports en_out/signed_out/sat_out (out, 1 each), pass_out (out, DATA_WIDTH) and psum_out (out, ACC_WIDTH) as registered row/column outputs.
REQ-017 SHALL have ports w_wen_out (out, 1) and w_out (out, DATA_WIDTH) as the registered weight-chain forward.
REQ-018 SHALL have status ports wbuf_full, wbuf_empty, w_valid, ovf_err and sat_flag, each out, 1 bit.

Function
REQ-019 When en_in=1, SHALL register on the next edge:
- pass_out=in, signed_out=signed_in, sat_out=sat_in, en_out=1;
- psum_out=psum_in+in*w_act, which gives 1-cycle latency.
REQ-020 SHALL form the product from DATA_WIDTH operands, sign- or zero-extended per signed_in, to ACC_WIDTH before the add.
REQ-021 When sat_in=0, SHALL wrap the sum modulo 2^ACC_WIDTH and register sat_flag=0.
REQ-022 When sat_in=1, SHALL clamp the sum and register sat_flag=1 if clamping occurred, else 0:
- signed_in=1: clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1];
- signed_in=0: clamp to [0, 2^ACC_WIDTH-1].
REQ-023 When w_valid=0, SHALL use a product of 0, so psum_out=psum_in (sat_flag=0).
REQ-024 When en_in=0, SHALL hold pass_out, psum_out, signed_out and sat_out, and register en_out=0 and sat_flag=0.
REQ-025 SHALL register w_wen_out=w_wen_in each cycle; w_out=w_in when w_wen_in=1, else 0.
REQ-026 SHALL push w_in into the FIFO only when w_push_in=1 and w_wen_in=1.
REQ-027 SHALL drop a push to a full FIFO that has no same-cycle pop, and set ovf_err, which stays 1 until rst.
REQ-028 On w_swap_in=1 with the FIFO non-empty, SHALL load the head into w_act, set w_valid=1 and pop, all on the next edge.
REQ-029 On w_swap_in=1 with the FIFO empty, SHALL leave w_act and w_valid unchanged; no bypass of a same-cycle push.
REQ-030 On w_clear_in=1 without an effective swap, SHALL set w_act=0 and w_valid=0; an effective swap in the same cycle wins over clear.
REQ-031 On push and pop in the same cycle with the FIFO non-empty (including full), SHALL perform both and leave the occupancy unchanged.
REQ-032 SHALL wrap the FIFO read/write pointers modulo WBUF_DEPTH and keep occupancy in 0..WBUF_DEPTH.
REQ-033 SHALL drive wbuf_full=(occupancy==WBUF_DEPTH) and wbuf_empty=(occupancy==0), both decoded from registered state.
REQ-034 A MAC in a swap or clear cycle SHALL use the old w_act; the new weight applies from the following cycle.

Reset
REQ-035 While rst=1, SHALL force asynchronously:
- outputs: all outputs 0 except wbuf_empty=1;
- internal state: w_act=0, pointers=0, occupancy=0, FIFO contents don't-care.
REQ-036 Reset asserted mid-operation SHALL abort any in-flight push, swap or MAC; the first edge after deassertion behaves as from the idle state.

Verification
REQ-037 Bench SHALL cover the signed MAC: DATA=16/ACC=32; push and swap w=-3; en_in with in=5, psum_in=100, signed -> next cycle psum_out=85, en_out=1, pass_out=5.
REQ-038 Bench SHALL cover saturation: signed, sat_in=1, w=0x7FFF, in=0x7FFF, psum_in=0x7FFFFFFF -> psum_out=0x7FFFFFFF, sat_flag=1; the same stimulus with sat_in=0 -> wrapped sum, sat_flag=0.
REQ-039 Bench SHALL cover FIFO fill: DEPTH=4, push 1,2,3,4 -> wbuf_full=1; push 5 alone -> dropped, ovf_err=1; four swaps -> w_act sequence 1,2,3,4, then wbuf_empty=1.
REQ-040 Bench SHALL cover simultaneous events:
- full FIFO, push+swap in one cycle -> occupancy stays 4;
- empty FIFO, push+swap -> w_valid unchanged, occupancy 1;
- swap+clear with FIFO non-empty -> w_valid=1.
REQ-041 Bench SHALL cover clear: w_clear_in, then en_in with psum_in=7 -> psum_out=7; w_wen_in=1, w_in=9 -> w_out=9 next cycle, 0 when w_wen_in drops.
REQ-042 Bench SHALL cover mid-operation reset: assert rst with FIFO holding 2 entries and en_in=1 -> all outputs 0 at once with wbuf_empty=1; after release, a swap does not change w_valid.
